// File: rtl/seg7_pkg.sv
// Shared types, segment table and BCD step helpers for the fading 7-seg counter.
// Contents: bcd_t, bcd_step_t, SEG_TABLE (digits 0..9, {A..G,DP}, A = MSB), SEG_BLANK,
//           bcd_inc / bcd_dec (one-digit step with carry / borrow out).
package seg7_pkg;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned SEG_W = 8;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef struct packed {
    logic c;
    bcd_t v;
  } bcd_step_t;

  localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;

  // Index 0 is the rightmost entry.
  localparam logic [9:0][SEG_W-1:0] SEG_TABLE = {
    8'hF6, 8'hFE, 8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
  };

  // One-digit increment; carry out when rolling 9 -> 0.
  function automatic bcd_step_t bcd_inc(input bcd_t d);
    bcd_step_t r;
    if (d >= 4'd9) begin
      r.c = 1'b1;
      r.v = '0;
    end else begin
      r.c = 1'b0;
      r.v = d + 4'd1;
    end
    return r;
  endfunction

  // One-digit decrement; borrow out when rolling 0 -> 9.
  function automatic bcd_step_t bcd_dec(input bcd_t d);
    bcd_step_t r;
    if (d == 4'd0) begin
      r.c = 1'b1;
      r.v = 4'd9;
    end else begin
      r.c = 1'b0;
      r.v = d - 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to segment decoder.
// Ports: bcd (in, 4b digit), seg_c (out, 8b {A..G,DP}); codes above 9 decode to blank.
module seg7_decode
  import seg7_pkg::*;
(
  input  bcd_t             bcd,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    if (bcd <= 4'd9) seg_c = SEG_TABLE[bcd];
  end

endmodule

// File: rtl/seg7_fade_counter_mux.sv
// N-digit BCD up/down counter on a multiplexed common-cathode 7-seg display; each digit
// PWM-dithers from its old to its new value during the first half of every count period.
// Ports: CLK, RST_N (async, active-low), EN, UP_DN, CLR (sync clear),
//        SEG[7:0] {A..G,DP}, DIG one-hot digit select, COUNT BCD value, WRAP wrap pulse.
//        SEG/DIG/COUNT/WRAP are registered.
// Config macro: SEG7_LZ_BLANK_EN -- blank digits above the highest non-zero shown digit.
module seg7_fade_counter_mux
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned PRESC_W = 24,
  parameter int unsigned SCAN_W  = 10
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    EN,
  input  logic                    UP_DN,
  input  logic                    CLR,
  output logic [SEG_W-1:0]        SEG,
  output logic [DIGITS-1:0]       DIG,
  output logic [BCD_W*DIGITS-1:0] COUNT,
  output logic                    WRAP
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned S_W   = SCAN_W + IDX_W;

  logic [PRESC_W-1:0]    p_q, p_d;
  bcd_t [DIGITS-1:0]     new_q, new_d;
  bcd_t [DIGITS-1:0]     old_q, old_d;
  logic [4:0]            acc_q, acc_d;
  logic [S_W-1:0]        s_q, s_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic [DIGITS-1:0]     dig_q, dig_d;
  logic                  wrap_q, wrap_d;

  logic                  tick_c;
  logic [3:0]            duty_c;
  logic                  show_new_c;
  bcd_t [DIGITS-1:0]     shown_c;
  logic [IDX_W-1:0]      idx_c;
  bcd_t                  digit_c;
  logic [SEG_W-1:0]      dec_seg_c;

  assign tick_c     = &p_q;
  assign duty_c     = p_q[PRESC_W-2 -: 4];
  // Old value shows only while the dither has not fired and we are in the first half.
  assign show_new_c = p_q[PRESC_W-1] | acc_q[4];
  assign shown_c    = show_new_c ? new_q : old_q;
  assign idx_c      = s_q[S_W-1 -: IDX_W];

  // Prescaler, counter ripple, fade accumulator and wrap detect.
  always_comb begin : count_next
    bcd_t [DIGITS-1:0] nxt;
    bcd_step_t         st;
    logic              c;
    nxt    = new_q;
    st     = '0;
    c      = 1'b1;
    p_d    = p_q + PRESC_W'(1);
    acc_d  = {1'b0, acc_q[3:0]} + {1'b0, duty_c};
    old_d  = old_q;
    new_d  = new_q;
    wrap_d = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (c) begin
        st     = UP_DN ? bcd_inc(new_q[i]) : bcd_dec(new_q[i]);
        nxt[i] = st.v;
        c      = st.c;
      end
    end
    if (CLR) begin
      p_d   = '0;
      acc_d = '0;
      old_d = '0;
      new_d = '0;
    end else if (tick_c) begin
      old_d = new_q;
      if (EN) begin
        new_d  = nxt;
        wrap_d = c;
      end
    end
  end

  // Scan counter: idx wraps at DIGITS-1 even when DIGITS is not a power of two.
  always_comb begin : scan_next
    s_d = s_q + S_W'(1);
    if ((idx_c == IDX_W'(DIGITS - 1)) && (&s_q[SCAN_W-1:0])) s_d = '0;
  end

  // Select the digit under scan and its one-hot enable.
  always_comb begin : digit_sel
    digit_c = '0;
    dig_d   = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_c == IDX_W'(i)) begin
        digit_c  = shown_c[i];
        dig_d[i] = 1'b1;
      end
    end
  end

  seg7_decode u_decode (
    .bcd   (digit_c),
    .seg_c (dec_seg_c)
  );

`ifdef SEG7_LZ_BLANK_EN
  logic keep_c;

  // Keep the digit if it is digit 0 or any shown digit at or above it is non-zero.
  always_comb begin : lz_blank
    keep_c = (idx_c == '0);
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if ((IDX_W'(i) >= idx_c) && (shown_c[i] != '0)) keep_c = 1'b1;
    end
  end

  assign seg_d = keep_c ? dec_seg_c : SEG_BLANK;
`else
  assign seg_d = dec_seg_c;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      p_q    <= '0;
      new_q  <= '0;
      old_q  <= '0;
      acc_q  <= '0;
      s_q    <= '0;
      seg_q  <= '0;
      dig_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      p_q    <= p_d;
      new_q  <= new_d;
      old_q  <= old_d;
      acc_q  <= acc_d;
      s_q    <= s_d;
      seg_q  <= seg_d;
      dig_q  <= dig_d;
      wrap_q <= wrap_d;
    end
  end

  assign SEG   = seg_q;
  assign DIG   = dig_q;
  assign COUNT = new_q;
  assign WRAP  = wrap_q;

endmodule
